load_store_unit: RTL



---
 rtl/load_store_unit_if.sv | 24 ++
 rtl/load_store_unit.sv | 137 +++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Latency: none; wires only. mem_rdata is valid in the cycle mem_ready is high.
// Backpressure: the master holds every mem_* output stable while mem_valid is high and mem_ready is low.
// Signals: mem_valid/mem_ready handshake, mem_we write enable, mem_addr word-aligned
// byte address, mem_wdata lane-replicated store data, mem_wstrb byte strobes, mem_rdata read word.
interface load_store_unit_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: core execute-stage request -> word-addressed data bus.
// Latency: 3 cycles (IDLE, BUS, DONE) with mem_ready high, +1 per wait cycle; faults finish in 2.
// Backpressure: stall holds the core through IDLE-with-request and BUS; the bus stalls us via mem_ready.
// Ports: clk/reset (sync, active-high); req_* core request held until done; stall/done/fault
// to the core; load_data extended load result; mem master side of load_store_unit_if.
module load_store_unit (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_we,
    input  logic [2:0]               req_funct3,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     stall,
    output logic                     done,
    output logic                     fault,
    output logic [31:0]              load_data,
    load_store_unit_if.master        mem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  funct3_q;
    logic [1:0]  off_q;

    logic        req_fault;
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    // Decode size, alignment and store lanes straight off the request.
    // BU/HU share the B/H lane pattern; they only differ on the load side.
    always_comb begin
        req_fault = 1'b0;
        st_strb   = 4'b1111;
        st_data   = req_wdata;
        case (req_funct3)
            3'b000, 3'b100: begin
                st_strb = 4'b0001 << req_addr[1:0];
                st_data = {4{req_wdata[7:0]}};
            end
            3'b001, 3'b101: begin
                req_fault = req_addr[0];
                st_strb   = 4'b0011 << req_addr[1:0];
                st_data   = {2{req_wdata[15:0]}};
            end
            3'b010: begin
                req_fault = |req_addr[1:0];
            end
            default: begin
                req_fault = 1'b1;
            end
        endcase
    end

    function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] shifted;
        shifted = rdata >> {off, 3'b000};
        case (f3)
            3'b000:  extend_load = {{24{shifted[7]}}, shifted[7:0]};
            3'b100:  extend_load = {24'd0, shifted[7:0]};
            3'b001:  extend_load = {{16{shifted[15]}}, shifted[15:0]};
            3'b101:  extend_load = {16'd0, shifted[15:0]};
            default: extend_load = shifted;
        endcase
    endfunction

    // Depends on req_valid combinationally so the core freezes in the same
    // cycle it presents the request. Low in DONE so the core advances then.
    assign stall = ((state == IDLE) && req_valid) || (state == BUS);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            done          <= 1'b0;
            fault         <= 1'b0;
            load_data     <= 32'd0;
            funct3_q      <= 3'd0;
            off_q         <= 2'd0;
            mem.mem_valid <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= 32'd0;
            mem.mem_wdata <= 32'd0;
            mem.mem_wstrb <= 4'b0000;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_fault) begin
                            // Illegal or misaligned: report without touching the bus.
                            state <= DONE;
                            done  <= 1'b1;
                            fault <= 1'b1;
                        end else begin
                            state         <= BUS;
                            mem.mem_valid <= 1'b1;
                            mem.mem_we    <= req_we;
                            mem.mem_addr  <= {req_addr[31:2], 2'b00};
                            mem.mem_wdata <= st_data;
                            mem.mem_wstrb <= req_we ? st_strb : 4'b0000;
                            funct3_q      <= req_funct3;
                            off_q         <= req_addr[1:0];
                        end
                    end
                end
                BUS: begin
                    if (mem.mem_ready) begin
                        state         <= DONE;
                        done          <= 1'b1;
                        mem.mem_valid <= 1'b0;
                        if (!mem.mem_we) begin
                            load_data <= extend_load(mem.mem_rdata, funct3_q, off_q);
                        end
                    end
                end
                DONE: begin
                    // The request still presented now is the one just finished.
                    state <= IDLE;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    fault <= 1'b0;
                end
            endcase
        end
    end

endmodule
